// File: rtl/lfsr_burst_sched.sv
// lfsr_burst_sched: round-robin arbiter that seeds a shared external LFSR per grant
// and streams the requested number of pattern words over valid/ready.
`default_nettype none

module lfsr_burst_sched #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 16,
  parameter int LEN_W    = 8
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic [NUM_REQ-1:0]          i_Req,
  input  logic [NUM_REQ*NUM_BITS-1:0] i_Seed,
  input  logic [NUM_REQ*LEN_W-1:0]    i_Len,
  output logic [NUM_REQ-1:0]          o_Grant,
  output logic                        o_Lfsr_Enable,
  output logic                        o_Lfsr_Seed_DV,
  output logic [NUM_BITS-1:0]         o_Lfsr_Seed_Data,
  input  logic [NUM_BITS-1:0]         i_Lfsr_Data,
  output logic [NUM_BITS-1:0]         o_Data,
  output logic                        o_Valid,
  input  logic                        i_Ready,
  output logic                        o_Last,
  output logic                        o_Done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEED   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    gidx_q, gidx_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;

  logic                pick_found;
  logic [PTR_W-1:0]    pick_idx;
  logic                in_seed;
  logic                in_stream;
  logic                last_word;

  // Index arithmetic modulo NUM_REQ, valid for non-power-of-two requester counts.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && i_Req[wrap_add(rr_ptr_q, i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign in_seed   = (state_q == S_SEED);
  assign in_stream = (state_q == S_STREAM);
  assign last_word = in_stream && (cnt_q == LEN_W'(len_q - 1'b1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    seed_d   = seed_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d           = S_SEED;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          seed_d            = i_Seed[pick_idx*NUM_BITS +: NUM_BITS];
          len_d             = i_Len[pick_idx*LEN_W +: LEN_W];
          cnt_d             = '0;
        end
      end
      S_SEED: begin
        state_d = (len_q == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (i_Ready) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        rr_ptr_d = wrap_add(gidx_q, 1);
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      seed_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      seed_q   <= seed_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs depend only on registered state and i_Ready; the LFSR steps only on a handshake.
  assign o_Grant          = grant_q;
  assign o_Lfsr_Seed_DV   = in_seed;
  assign o_Lfsr_Enable    = in_seed || (in_stream && i_Ready);
  assign o_Lfsr_Seed_Data = in_seed ? seed_q : '0;
  assign o_Valid          = in_stream;
  assign o_Data           = in_stream ? i_Lfsr_Data : '0;
  assign o_Last           = last_word;
  assign o_Done           = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_burst_sched.sv
// tb_lfsr_burst_sched: directed checks of lfsr_burst_sched with a 16-bit XNOR LFSR
// (taps 16,15,13,4) attached as the external pattern generator.
`default_nettype none

module tb_lfsr_burst_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] seed;
  logic [31:0] len;
  logic        ready;
  logic [3:0]  grant;
  logic        lfsr_en;
  logic        lfsr_dv;
  logic [15:0] lfsr_seed;
  logic [15:0] lfsr_q = 16'h0000;
  logic [15:0] data;
  logic        valid;
  logic        last;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;
  int hs_cnt = 0;

  lfsr_burst_sched #(.NUM_REQ(4), .NUM_BITS(16), .LEN_W(8)) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Req(req),
    .i_Seed(seed),
    .i_Len(len),
    .o_Grant(grant),
    .o_Lfsr_Enable(lfsr_en),
    .o_Lfsr_Seed_DV(lfsr_dv),
    .o_Lfsr_Seed_Data(lfsr_seed),
    .i_Lfsr_Data(lfsr_q),
    .o_Data(data),
    .o_Valid(valid),
    .i_Ready(ready),
    .o_Last(last),
    .o_Done(done)
  );

  always #5 clk = ~clk;

  // External LFSR: loads on seed strobe, otherwise shifts in the XNOR of the taps.
  always @(posedge clk) begin
    if (lfsr_en) begin
      if (lfsr_dv) lfsr_q <= lfsr_seed;
      else         lfsr_q <= {lfsr_q[14:0], ~(lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3])};
    end
  end

  always @(posedge clk) if (valid && ready) hs_cnt++;

  task automatic cyc();
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic wait_seed(input string name);
    int n;
    n = 0;
    while (!lfsr_dv && n < 12) begin
      cyc(); #1;
      n++;
    end
    n_cmp++;
    if (lfsr_dv !== 1'b1) begin
      $display("FAIL %s_seed_wait got dv=%b required dv=1", name, lfsr_dv);
      n_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; ready = 1'b1;
    cyc(); cyc(); #1;
    n_cmp++;
    if ({grant, valid, last, done, lfsr_en, lfsr_dv, lfsr_seed, data} !== 41'd0) begin
      $display("FAIL reset_outputs got %h required 0",
               {grant, valid, last, done, lfsr_en, lfsr_dv, lfsr_seed, data});
      n_err++;
    end
    req = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [15:0] w [3];
    w[0] = 16'h0001; w[1] = 16'h0003; w[2] = 16'h0007;
    cyc(); req = 4'b0001; seed[15:0] = 16'h0001; len[7:0] = 8'd3; ready = 1'b1; #1;
    n_cmp++;
    if ({grant, valid, lfsr_en} !== 6'd0) begin
      $display("FAIL single_idle got %b required 000000", {grant, valid, lfsr_en});
      n_err++;
    end
    cyc(); req = 4'b0000; #1;
    n_cmp++;
    if ({grant, lfsr_en, lfsr_dv, lfsr_seed, valid} !== {4'b0001, 1'b1, 1'b1, 16'h0001, 1'b0}) begin
      $display("FAIL single_seed got %h required %h", {grant, lfsr_en, lfsr_dv, lfsr_seed, valid},
               {4'b0001, 1'b1, 1'b1, 16'h0001, 1'b0});
      n_err++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      n_cmp++;
      if ({valid, last, data, grant, lfsr_en, lfsr_dv} !== {1'b1, (i == 2), w[i], 4'b0001, 1'b1, 1'b0}) begin
        $display("FAIL single_word%0d got v=%b l=%b d=%h g=%b en=%b dv=%b required v=1 l=%b d=%h g=0001 en=1 dv=0",
                 i, valid, last, data, grant, lfsr_en, lfsr_dv, (i == 2), w[i]);
        n_err++;
      end
    end
    cyc(); #1;
    n_cmp++;
    if ({done, valid, grant, lfsr_en, data} !== {1'b1, 1'b0, 4'b0001, 1'b0, 16'h0}) begin
      $display("FAIL single_done got done=%b v=%b g=%b en=%b d=%h required 1 0 0001 0 0000",
               done, valid, grant, lfsr_en, data);
      n_err++;
    end
    cyc(); #1;
    n_cmp++;
    if ({done, grant} !== 5'd0) begin
      $display("FAIL single_idle_after got %b required 00000", {done, grant});
      n_err++;
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    cyc(); req = 4'b0001; seed[15:0] = 16'h0001; len[7:0] = 8'd3; ready = 1'b1; #1;
    hs0 = hs_cnt;
    cyc(); req = 4'b0000; #1;
    cyc(); #1;
    n_cmp++;
    if ({valid, data} !== {1'b1, 16'h0001}) begin
      $display("FAIL bp_word0 got v=%b d=%h required v=1 d=0001", valid, data);
      n_err++;
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); ready = 1'b0; #1;
      n_cmp++;
      if ({valid, last, data, lfsr_en} !== {1'b1, 1'b0, 16'h0003, 1'b0}) begin
        $display("FAIL bp_stall%0d got v=%b l=%b d=%h en=%b required v=1 l=0 d=0003 en=0",
                 i, valid, last, data, lfsr_en);
        n_err++;
      end
    end
    cyc(); ready = 1'b1; #1;
    n_cmp++;
    if ({valid, data, lfsr_en} !== {1'b1, 16'h0003, 1'b1}) begin
      $display("FAIL bp_release got v=%b d=%h en=%b required v=1 d=0003 en=1", valid, data, lfsr_en);
      n_err++;
    end
    cyc(); #1;
    n_cmp++;
    if ({valid, last, data} !== {1'b1, 1'b1, 16'h0007}) begin
      $display("FAIL bp_word2 got v=%b l=%b d=%h required v=1 l=1 d=0007", valid, last, data);
      n_err++;
    end
    cyc(); #1;
    n_cmp++;
    if ({done, hs_cnt - hs0} !== {1'b1, 32'd3}) begin
      $display("FAIL bp_handshakes got done=%b hs=%0d required done=1 hs=3", done, hs_cnt - hs0);
      n_err++;
    end
  endtask

  task automatic test_zero_len();
    cyc(); req = 4'b0100; seed[47:32] = 16'hABCD; len[23:16] = 8'd0; #1;
    cyc(); req = 4'b0000; #1;
    n_cmp++;
    if ({grant, lfsr_en, lfsr_dv, lfsr_seed, valid} !== {4'b0100, 1'b1, 1'b1, 16'hABCD, 1'b0}) begin
      $display("FAIL zero_seed got g=%b en=%b dv=%b sd=%h v=%b required 0100 1 1 abcd 0",
               grant, lfsr_en, lfsr_dv, lfsr_seed, valid);
      n_err++;
    end
    cyc(); #1;
    n_cmp++;
    if ({done, valid, grant, lfsr_en, lfsr_dv} !== {1'b1, 1'b0, 4'b0100, 1'b0, 1'b0}) begin
      $display("FAIL zero_done got done=%b v=%b g=%b en=%b dv=%b required 1 0 0100 0 0",
               done, valid, grant, lfsr_en, lfsr_dv);
      n_err++;
    end
    // Pointer should now sit at 3: with req0 and req3 pending, req3 wins.
    cyc(); req = 4'b1001; len[31:24] = 8'd1; seed[63:48] = 16'h5A5A; len[7:0] = 8'd1; #1;
    cyc(); req = 4'b0000; #1;
    n_cmp++;
    if (grant !== 4'b1000) begin
      $display("FAIL zero_rr_ptr got grant=%b required 1000", grant);
      n_err++;
    end
    cyc(); cyc(); #1;
  endtask

  task automatic test_round_robin();
    logic [15:0] s [4];
    int last_v;
    s[0] = 16'h0001; s[1] = 16'h1234; s[2] = 16'h00F0; s[3] = 16'hBEEF;
    last_v = 0;
    cyc(); req = 4'b1111; len = {8'd1, 8'd1, 8'd1, 8'd1};
    seed = {s[3], s[2], s[1], s[0]}; #1;
    for (int b = 0; b < 5; b++) begin
      wait_seed("rr");
      n_cmp++;
      if (grant !== (4'b0001 << (b % 4))) begin
        $display("FAIL rr_grant%0d got %b required %b", b, grant, 4'b0001 << (b % 4));
        n_err++;
      end
      if (b == 4) req = 4'b0000;
      cyc(); #1;
      n_cmp++;
      if ({valid, last, data} !== {1'b1, 1'b1, s[b % 4]}) begin
        $display("FAIL rr_word%0d got v=%b l=%b d=%h required v=1 l=1 d=%h", b, valid, last, data, s[b % 4]);
        n_err++;
      end
      if (b > 0) begin
        n_cmp++;
        if (cyc_no - last_v < 4) begin
          $display("FAIL rr_gap%0d got %0d cycles required >=4", b, cyc_no - last_v);
          n_err++;
        end
      end
      last_v = cyc_no;
      cyc(); #1;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    cyc(); req = 4'b0010; seed[31:16] = 16'h1234; len[15:8] = 8'd5; ready = 1'b1; #1;
    wait_seed("rst");
    req = 4'b0000;
    cyc(); #1;
    n_cmp++;
    if ({valid, data} !== {1'b1, 16'h1234}) begin
      $display("FAIL rst_word0 got v=%b d=%h required v=1 d=1234", valid, data);
      n_err++;
    end
    cyc(); rst_n = 1'b0; #1;
    n_cmp++;
    if ({valid, data} !== {1'b1, 16'h2468}) begin
      $display("FAIL rst_word1 got v=%b d=%h required v=1 d=2468", valid, data);
      n_err++;
    end
    cyc(); #1;
    n_cmp++;
    if ({grant, valid, last, done, lfsr_en, lfsr_dv, lfsr_seed, data} !== 41'd0) begin
      $display("FAIL rst_mid_outputs got %h required 0",
               {grant, valid, last, done, lfsr_en, lfsr_dv, lfsr_seed, data});
      n_err++;
    end
    rst_n = 1'b1; req = 4'b1010;
    wait_seed("rst2");
    n_cmp++;
    if ({grant, lfsr_seed} !== {4'b0010, 16'h1234}) begin
      $display("FAIL rst_regrant got g=%b sd=%h required g=0010 sd=1234", grant, lfsr_seed);
      n_err++;
    end
    req = 4'b0000;
    cyc(); #1;
    n_cmp++;
    if ({valid, data} !== {1'b1, 16'h1234}) begin
      $display("FAIL rst_restart got v=%b d=%h required v=1 d=1234", valid, data);
      n_err++;
    end
    n = 0;
    while (!done && n < 20) begin
      cyc(); #1;
      n++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      $display("FAIL rst_done_wait got done=%b required 1", done);
      n_err++;
    end
  endtask

  task automatic test_req_drop();
    cyc(); req = 4'b0001; seed[15:0] = 16'h0001; len[7:0] = 8'd2; ready = 1'b1; #1;
    wait_seed("drop");
    req = 4'b0000; seed[15:0] = 16'hFFFF; len[7:0] = 8'd7;
    cyc(); #1;
    n_cmp++;
    if ({valid, last, data} !== {1'b1, 1'b0, 16'h0001}) begin
      $display("FAIL drop_word0 got v=%b l=%b d=%h required v=1 l=0 d=0001", valid, last, data);
      n_err++;
    end
    cyc(); #1;
    n_cmp++;
    if ({valid, last, data} !== {1'b1, 1'b1, 16'h0003}) begin
      $display("FAIL drop_word1 got v=%b l=%b d=%h required v=1 l=1 d=0003", valid, last, data);
      n_err++;
    end
    cyc(); #1;
    n_cmp++;
    if ({done, valid, grant} !== {1'b1, 1'b0, 4'b0001}) begin
      $display("FAIL drop_done got done=%b v=%b g=%b required 1 0 0001", done, valid, grant);
      n_err++;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; seed = '0; len = '0; ready = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_zero_len();
    test_round_robin();
    test_reset_mid();
    test_req_drop();
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
